// File: rtl/dbg_run_sched.sv
// Run-control scheduler for the debug core: arbitrates halt/step/resume requests and drives the
// glitch-free clock gate that produces dbg_clk from sys_clk.
module dbg_run_sched #(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned STEP_W = 8
) (
  input  logic              sys_clk,
  input  logic              dbg_rst,
  input  logic              halt_stb,
  input  logic              step_stb,
  input  logic              resume_stb,
  input  logic [STEP_W-1:0] step_count,
  input  logic              ext_halt_req,
  input  logic              bkpt_en,
  input  logic [CNT_W-1:0]  bkpt_cycle,
  output logic              dbg_clk,
  output logic              halted,
  output logic              stepping,
  output logic [1:0]        halt_cause,
  output logic [CNT_W-1:0]  cycle_cnt
);

  typedef enum logic [1:0] {StRun, StHalt, StStep} state_e;

  localparam logic [1:0] CauseNone = 2'b00;
  localparam logic [1:0] CauseJtag = 2'b01;
  localparam logic [1:0] CauseExt  = 2'b10;
  localparam logic [1:0] CauseBkpt = 2'b11;

  state_e              state_q, state_d;
  logic                clk_en_q, clk_en_d;
  logic                clk_gate_q;
  logic [CNT_W-1:0]    cycle_cnt_q, cycle_cnt_d;
  logic [1:0]          halt_cause_q, halt_cause_d;
  logic [STEP_W-1:0]   step_rem_q, step_rem_d;
  logic                bkpt_armed_q, bkpt_armed_d;
  logic                bkpt_en_q;
  logic                bkpt_hit;

  assign bkpt_hit = (state_q == StRun) & bkpt_armed_q & (cycle_cnt_q == bkpt_cycle);

  always_comb begin
    bkpt_armed_d = bkpt_armed_q;
    if (!bkpt_en) begin
      bkpt_armed_d = 1'b0;
    end else if (!bkpt_en_q) begin
      bkpt_armed_d = 1'b1;
    end else if (bkpt_hit) begin
      bkpt_armed_d = 1'b0;
    end
  end

  // Counts the pulse that actually reaches dbg_clk at this edge.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if (clk_gate_q) begin
      cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    clk_en_d     = clk_en_q;
    halt_cause_d = halt_cause_q;
    step_rem_d   = step_rem_q;
    unique case (state_q)
      StRun: begin
        if (halt_stb || bkpt_hit || ext_halt_req) begin
          state_d  = StHalt;
          clk_en_d = 1'b0;
          if (halt_stb) begin
            halt_cause_d = CauseJtag;
          end else if (bkpt_hit) begin
            halt_cause_d = CauseBkpt;
          end else begin
            halt_cause_d = CauseExt;
          end
        end
      end
      StHalt: begin
        if (step_stb) begin
          state_d    = StStep;
          clk_en_d   = 1'b1;
          step_rem_d = (step_count == '0) ? STEP_W'(1) : step_count;
        end else if (resume_stb && !ext_halt_req) begin
          state_d      = StRun;
          clk_en_d     = 1'b1;
          halt_cause_d = CauseNone;
        end
      end
      StStep: begin
        step_rem_d = step_rem_q - STEP_W'(1);
        if (halt_stb) begin
          state_d      = StHalt;
          clk_en_d     = 1'b0;
          halt_cause_d = CauseJtag;
        end else if (step_rem_q == STEP_W'(1)) begin
          state_d  = StHalt;
          clk_en_d = 1'b0;
        end
      end
      default: begin
        state_d  = StRun;
        clk_en_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge dbg_rst) begin
    if (!dbg_rst) begin
      state_q      <= StRun;
      clk_en_q     <= 1'b1;
      cycle_cnt_q  <= '0;
      halt_cause_q <= CauseNone;
      step_rem_q   <= '0;
      bkpt_armed_q <= 1'b0;
      bkpt_en_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      clk_en_q     <= clk_en_d;
      cycle_cnt_q  <= cycle_cnt_d;
      halt_cause_q <= halt_cause_d;
      step_rem_q   <= step_rem_d;
      bkpt_armed_q <= bkpt_armed_d;
      bkpt_en_q    <= bkpt_en;
    end
  end

  // Gate updates while sys_clk is low so dbg_clk never sees a partial pulse.
  always_ff @(negedge sys_clk or negedge dbg_rst) begin
    if (!dbg_rst) begin
      clk_gate_q <= 1'b1;
    end else begin
      clk_gate_q <= clk_en_q;
    end
  end

  assign dbg_clk    = sys_clk & clk_gate_q;
  assign halted     = (state_q == StHalt);
  assign stepping   = (state_q == StStep);
  assign halt_cause = halt_cause_q;
  assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_dbg_run_sched.sv
// Self-checking bench for dbg_run_sched: directed table, multi-cycle corner sequences and a
// randomized run, all compared against a cycle-level behavioural model.
module tb_dbg_run_sched;
  localparam int CNT_W  = 8;
  localparam int STEP_W = 8;
  localparam int MRUN = 0, MHALT = 1, MSTEP = 2;

  logic              sys_clk = 1'b0;
  logic              dbg_rst = 1'b0;
  logic              halt_stb = 1'b0, step_stb = 1'b0, resume_stb = 1'b0;
  logic [STEP_W-1:0] step_count = '0;
  logic              ext_halt_req = 1'b0, bkpt_en = 1'b0;
  logic [CNT_W-1:0]  bkpt_cycle = '0;
  logic              dbg_clk, halted, stepping;
  logic [1:0]        halt_cause;
  logic [CNT_W-1:0]  cycle_cnt;

  dbg_run_sched #(.CNT_W(CNT_W), .STEP_W(STEP_W)) dut (
    .sys_clk     (sys_clk),
    .dbg_rst     (dbg_rst),
    .halt_stb    (halt_stb),
    .step_stb    (step_stb),
    .resume_stb  (resume_stb),
    .step_count  (step_count),
    .ext_halt_req(ext_halt_req),
    .bkpt_en     (bkpt_en),
    .bkpt_cycle  (bkpt_cycle),
    .dbg_clk     (dbg_clk),
    .halted      (halted),
    .stepping    (stepping),
    .halt_cause  (halt_cause),
    .cycle_cnt   (cycle_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int dbg_pulses;
  always @(posedge dbg_clk or negedge dbg_rst) begin
    if (!dbg_rst) dbg_pulses <= 0;
    else dbg_pulses <= dbg_pulses + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a pulse reaches dbg_clk at an edge iff the previous edge left us not halted.
  int m_mode, m_cause, m_left, m_cnt, m_pulses;
  bit m_armed, m_en_prev, m_gate;

  task automatic model_reset();
    m_mode = MRUN; m_cause = 0; m_left = 0; m_cnt = 0; m_pulses = 0;
    m_armed = 0; m_en_prev = 0; m_gate = 1;
  endtask

  task automatic model_edge();
    bit pulse;
    bit hit;
    pulse = m_gate;
    hit = (m_mode == MRUN) && m_armed && (m_cnt == int'(bkpt_cycle));
    if (!bkpt_en) m_armed = 0;
    else if (!m_en_prev) m_armed = 1;
    else if (hit) m_armed = 0;
    m_en_prev = bkpt_en;
    case (m_mode)
      MRUN: if (halt_stb || hit || ext_halt_req) begin
        m_mode = MHALT;
        m_cause = halt_stb ? 1 : (hit ? 3 : 2);
      end
      MHALT: if (step_stb) begin
        m_left = (step_count == 0) ? 1 : int'(step_count);
        m_mode = MSTEP;
      end else if (resume_stb && !ext_halt_req) begin
        m_mode = MRUN;
        m_cause = 0;
      end
      default: begin
        m_left--;
        if (halt_stb) begin
          m_mode = MHALT;
          m_cause = 1;
        end else if (m_left == 0) begin
          m_mode = MHALT;
        end
      end
    endcase
    if (pulse) begin
      m_cnt = (m_cnt + 1) % (1 << CNT_W);
      m_pulses++;
    end
    m_gate = (m_mode != MHALT);
  endtask

  task automatic set_in(input bit h, input bit s, input bit r, input logic [7:0] sc, input bit e);
    halt_stb = h; step_stb = s; resume_stb = r; step_count = sc; ext_halt_req = e;
  endtask

  task automatic tick();
    @(posedge sys_clk);
    model_edge();
    #1;
    chk("m_halted", halted, m_mode == MHALT);
    chk("m_stepping", stepping, m_mode == MSTEP);
    chk("m_cause", halt_cause, m_cause);
    chk("m_cnt", cycle_cnt, m_cnt);
    chk("m_pulses", dbg_pulses, m_pulses);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    #1 dbg_rst = 1'b0;
    model_reset();
    #1;
    chk("rst_cnt", cycle_cnt, 0);
    chk("rst_halted", halted, 0);
    chk("rst_stepping", stepping, 0);
    chk("rst_cause", halt_cause, 0);
    @(negedge sys_clk);
    #1 dbg_rst = 1'b1;
  endtask

  typedef struct {
    bit h, s, r; logic [7:0] sc; bit e;
    bit eh, es; logic [1:0] ec; int cnt;
  } vec_t;
  vec_t tbl[22];

  initial begin
    int p0;
    bit seen;
    tbl[0]  = '{1, 0, 0, 8'd0, 0, 1, 0, 2'd1, 11};
    tbl[1]  = '{0, 0, 0, 8'd0, 0, 1, 0, 2'd1, 11};
    tbl[2]  = '{0, 0, 0, 8'd0, 0, 1, 0, 2'd1, 11};
    tbl[3]  = '{0, 0, 1, 8'd0, 0, 0, 0, 2'd0, 11};
    tbl[4]  = '{0, 0, 0, 8'd0, 0, 0, 0, 2'd0, 12};
    tbl[5]  = '{1, 0, 0, 8'd0, 0, 1, 0, 2'd1, 13};
    tbl[6]  = '{0, 1, 1, 8'd5, 0, 0, 1, 2'd1, 13};
    tbl[7]  = '{0, 0, 0, 8'd0, 0, 0, 1, 2'd1, 14};
    tbl[8]  = '{0, 0, 0, 8'd0, 0, 0, 1, 2'd1, 15};
    tbl[9]  = '{0, 0, 0, 8'd0, 0, 0, 1, 2'd1, 16};
    tbl[10] = '{0, 0, 0, 8'd0, 0, 0, 1, 2'd1, 17};
    tbl[11] = '{0, 0, 0, 8'd0, 0, 1, 0, 2'd1, 18};
    tbl[12] = '{0, 0, 0, 8'd0, 0, 1, 0, 2'd1, 18};
    tbl[13] = '{0, 1, 0, 8'd0, 0, 0, 1, 2'd1, 18};
    tbl[14] = '{0, 0, 0, 8'd0, 0, 1, 0, 2'd1, 19};
    tbl[15] = '{0, 0, 0, 8'd0, 0, 1, 0, 2'd1, 19};
    tbl[16] = '{0, 0, 1, 8'd0, 0, 0, 0, 2'd0, 19};
    tbl[17] = '{0, 0, 0, 8'd0, 1, 1, 0, 2'd2, 20};
    tbl[18] = '{0, 0, 1, 8'd0, 1, 1, 0, 2'd2, 20};
    tbl[19] = '{1, 0, 0, 8'd0, 1, 1, 0, 2'd2, 20};
    tbl[20] = '{0, 0, 1, 8'd0, 0, 0, 0, 2'd0, 20};
    tbl[21] = '{0, 0, 0, 8'd0, 0, 0, 0, 2'd0, 21};

    model_reset();
    #12 dbg_rst = 1'b1;

    // Free run after reset.
    for (int i = 0; i < 10; i++) tick();
    chk("run10_cnt", cycle_cnt, 10);
    chk("run10_pulses", dbg_pulses, 10);
    chk("run10_halted", halted, 0);
    chk("run10_cause", halt_cause, 0);

    // Directed halt / resume / step / external-halt table.
    foreach (tbl[i]) begin
      set_in(tbl[i].h, tbl[i].s, tbl[i].r, tbl[i].sc, tbl[i].e);
      tick();
      chk($sformatf("tbl%0d_halted", i), halted, tbl[i].eh);
      chk($sformatf("tbl%0d_stepping", i), stepping, tbl[i].es);
      chk($sformatf("tbl%0d_cause", i), halt_cause, tbl[i].ec);
      chk($sformatf("tbl%0d_cnt", i), cycle_cnt, tbl[i].cnt);
    end
    set_in(0, 0, 0, 0, 0);

    // Halt aborts a long step.
    set_in(1, 0, 0, 0, 0); tick();
    set_in(0, 1, 0, 8'd100, 0); tick();
    set_in(0, 0, 0, 0, 0);
    p0 = dbg_pulses;
    for (int i = 0; i < 30; i++) tick();
    set_in(1, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0); tick();
    chk("abort_halted", halted, 1);
    chk("abort_cause", halt_cause, 1);
    chk("abort_short", (dbg_pulses - p0) < 100, 1);

    // Reset in the middle of a step.
    set_in(0, 1, 0, 8'd100, 0); tick();
    set_in(0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) tick();
    chk("midstep_stepping", stepping, 1);
    do_reset();
    tick();
    chk("after_rst_cnt", cycle_cnt, 1);
    chk("after_rst_halted", halted, 0);

    // Breakpoint armed from reset, then no refire across wrap until re-armed.
    bkpt_cycle = 8'd20;
    bkpt_en = 1'b1;
    do_reset();
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      seen = halted;
    end
    chk("bkpt_halted", halted, 1);
    chk("bkpt_cause", halt_cause, 3);
    chk("bkpt_cnt", cycle_cnt, 21);
    set_in(0, 0, 1, 0, 0); tick();
    set_in(0, 0, 0, 0, 0);
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (halted) seen = 1;
    end
    chk("bkpt_no_refire", seen, 0);
    bkpt_en = 1'b0; tick();
    bkpt_en = 1'b1;
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      tick();
      seen = halted;
    end
    chk("bkpt_rearm_cause", halt_cause, 3);
    chk("bkpt_rearm_cnt", cycle_cnt, 21);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      halt_stb   = ($urandom_range(99) < 5);
      step_stb   = ($urandom_range(99) < 12);
      resume_stb = ($urandom_range(99) < 10);
      step_count = 8'($urandom_range(7));
      if ($urandom_range(99) < 4) ext_halt_req = ~ext_halt_req;
      if ($urandom_range(99) < 2) bkpt_en = ~bkpt_en;
      if ($urandom_range(99) < 2) bkpt_cycle = 8'($urandom);
      tick();
      if (i % 700 == 699) begin
        set_in(0, 0, 0, 0, 0);
        do_reset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
